// File: rtl/io_uart_pkg.sv
// =====================================================================
// io_uart_pkg : register offsets, STATUS bit indices, FSM encodings and
//               the divisor clamp shared by the io_uart files.  rev 1.0
// =====================================================================
`default_nettype none

package io_uart_pkg;

   localparam logic [1:0] REG_TXDATA  = 2'd0;
   localparam logic [1:0] REG_RXDATA  = 2'd1;
   localparam logic [1:0] REG_STATUS  = 2'd2;
   localparam logic [1:0] REG_DIVISOR = 2'd3;

   localparam int ST_TX_FULL    = 0;
   localparam int ST_TX_EMPTY   = 1;
   localparam int ST_TX_BUSY    = 2;
   localparam int ST_RX_VALID   = 3;
   localparam int ST_RX_OVERRUN = 4;

   localparam logic [15:0] MIN_DIV = 16'd2;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   function automatic logic [15:0] clamp_div(input logic [15:0] v);
      return (v < MIN_DIV) ? MIN_DIV : v;
   endfunction

endpackage

`default_nettype wire

// File: rtl/io_uart_fifo.sv
// =====================================================================
// io_uart_fifo : power-of-two FIFO with wrap-bit pointers and a
//                combinational head output.  rev 1.0
// =====================================================================
`default_nettype none

module io_uart_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             resetb,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic [WIDTH-1:0] din_i,
   output logic [WIDTH-1:0] dout_o,
   output logic             full_o,
   output logic             empty_o
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0]      wr_q, rd_q;
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic             do_push, do_pop;

   // Extra MSB distinguishes full from empty when the index bits match.
   assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty_o = (wr_q == rd_q);
   assign do_push = push_i && !full_o;
   assign do_pop  = pop_i && !empty_o;
   assign dout_o  = mem_q[rd_q[AW-1:0]];

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         wr_q <= '0;
         rd_q <= '0;
      end else begin
         if (do_push) wr_q <= wr_q + (AW+1)'(1);
         if (do_pop)  rd_q <= rd_q + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q[AW-1:0]] <= din_i;
   end

endmodule

`default_nettype wire

// File: rtl/io_uart.sv
// =====================================================================
// io_uart : memory-mapped 8N1 UART on the 8-bit I/O bus; the receiver
//           is built only when IO_UART_RX_EN is defined.  rev 1.0
// =====================================================================
`default_nettype none

module io_uart
   import io_uart_pkg::*;
#(
   parameter logic [3:0]  BASE_ADDR = 4'h1,
   parameter int          TX_DEPTH  = 4,
   parameter logic [15:0] DIV_RESET = 16'd104
) (
   input  logic        clk,
   input  logic        resetb,
   input  logic [7:0]  io_addr,
   input  logic        io_en,
   input  logic        io_we,
   input  logic [31:0] io_data_write,
   output logic [31:0] io_data_read,
   output logic        uart_tx,
   input  logic        uart_rx
);

   logic        sel, rd, wr;
   logic [1:0]  off;
   logic [15:0] div_q, div_d;
   logic        tx_full, tx_empty, tx_busy, tx_pop;
   logic [7:0]  tx_head;
   logic        rx_valid, rx_overrun;
   logic [7:0]  rx_byte;
   logic        unused_bits;

   assign sel = (io_addr[7:4] == BASE_ADDR);
   assign off = io_addr[3:2];
   assign rd  = sel && io_en && !io_we;
   assign wr  = sel && io_en && io_we;
   assign unused_bits = ^{io_addr[1:0], io_data_write[31:16]};

   assign div_d = (wr && off == REG_DIVISOR) ? clamp_div(io_data_write[15:0]) : div_q;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) div_q <= DIV_RESET;
      else         div_q <= div_d;
   end

   io_uart_fifo #(
      .DEPTH (TX_DEPTH),
      .WIDTH (8)
   ) u_txfifo (
      .clk     (clk),
      .resetb  (resetb),
      .push_i  (wr && off == REG_TXDATA),
      .pop_i   (tx_pop),
      .din_i   (io_data_write[7:0]),
      .dout_o  (tx_head),
      .full_o  (tx_full),
      .empty_o (tx_empty)
   );

   always_comb begin
      io_data_read = 32'b0;
      if (rd) begin
         case (off)
            REG_RXDATA:  io_data_read = {23'b0, rx_valid, rx_byte};
            REG_STATUS:  io_data_read = {27'b0, rx_overrun, rx_valid, tx_busy, tx_empty, tx_full};
            REG_DIVISOR: io_data_read = {16'b0, div_q};
            default:     io_data_read = 32'b0;
         endcase
      end
   end

   // ------------------------------------------------------------ TX
   tx_state_e   tx_state_q, tx_state_d;
   logic [15:0] tx_cnt_q, tx_cnt_d, tx_bdiv_q, tx_bdiv_d;
   logic [2:0]  tx_bit_q, tx_bit_d;
   logic [7:0]  tx_sh_q, tx_sh_d;
   logic        tx_q, tx_d, tx_bit_end;

   // Each bit latches its own length so divisor writes only bite at a boundary.
   assign tx_bit_end = (tx_cnt_q == tx_bdiv_q - 16'd1);
   assign tx_busy    = (tx_state_q != TX_IDLE);
   assign uart_tx    = tx_q;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bdiv_q  <= DIV_RESET;
         tx_bit_q   <= '0;
         tx_sh_q    <= '0;
         tx_q       <= 1'b1;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bdiv_q  <= tx_bdiv_d;
         tx_bit_q   <= tx_bit_d;
         tx_sh_q    <= tx_sh_d;
         tx_q       <= tx_d;
      end
   end

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q + 16'd1;
      tx_bdiv_d  = tx_bdiv_q;
      tx_bit_d   = tx_bit_q;
      tx_sh_d    = tx_sh_q;
      tx_pop     = 1'b0;
      case (tx_state_q)
         TX_IDLE: begin
            tx_cnt_d = '0;
            if (!tx_empty) begin
               tx_state_d = TX_START;
               tx_pop     = 1'b1;
               tx_sh_d    = tx_head;
               tx_bdiv_d  = div_q;
            end
         end
         TX_START: begin
            if (tx_bit_end) begin
               tx_state_d = TX_DATA;
               tx_bit_d   = '0;
               tx_cnt_d   = '0;
               tx_bdiv_d  = div_q;
            end
         end
         TX_DATA: begin
            if (tx_bit_end) begin
               tx_sh_d    = tx_sh_q >> 1;
               tx_cnt_d   = '0;
               tx_bdiv_d  = div_q;
               tx_bit_d   = tx_bit_q + 3'd1;
               if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
            end
         end
         TX_STOP: begin
            if (tx_bit_end) begin
               tx_cnt_d  = '0;
               tx_bdiv_d = div_q;
               if (!tx_empty) begin
                  tx_state_d = TX_START;
                  tx_pop     = 1'b1;
                  tx_sh_d    = tx_head;
               end else begin
                  tx_state_d = TX_IDLE;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   always_comb begin
      case (tx_state_d)
         TX_START: tx_d = 1'b0;
         TX_DATA:  tx_d = tx_sh_d[0];
         default:  tx_d = 1'b1;
      endcase
   end

   // ------------------------------------------------------------ RX
`ifdef IO_UART_RX_EN
   rx_state_e   rx_state_q, rx_state_d;
   logic [15:0] rx_cnt_q, rx_cnt_d;
   logic [2:0]  rx_bit_q, rx_bit_d;
   logic [7:0]  rx_sh_q, rx_sh_d, rx_byte_q, rx_byte_d;
   logic        rx_m_q, rx_s_q, rx_prev_q;
   logic        rx_valid_q, rx_valid_d, rx_ovr_q, rx_ovr_d;
   logic        rx_done, rd_rx, rd_st;

   assign rd_rx      = rd && off == REG_RXDATA;
   assign rd_st      = rd && off == REG_STATUS;
   assign rx_valid   = rx_valid_q;
   assign rx_overrun = rx_ovr_q;
   assign rx_byte    = rx_byte_q;

   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         rx_m_q     <= 1'b1;
         rx_s_q     <= 1'b1;
         rx_prev_q  <= 1'b1;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_sh_q    <= '0;
         rx_byte_q  <= '0;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
      end else begin
         rx_m_q     <= uart_rx;
         rx_s_q     <= rx_m_q;
         rx_prev_q  <= rx_s_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_sh_q    <= rx_sh_d;
         rx_byte_q  <= rx_byte_d;
         rx_valid_q <= rx_valid_d;
         rx_ovr_q   <= rx_ovr_d;
      end
   end

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q + 16'd1;
      rx_bit_d   = rx_bit_q;
      rx_sh_d    = rx_sh_q;
      rx_done    = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (rx_prev_q && !rx_s_q) rx_state_d = RX_START;
         end
         RX_START: begin
            if (rx_cnt_q >= (div_q >> 1) - 16'd1) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s_q ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_cnt_q >= div_q - 16'd1) begin
               rx_cnt_d = '0;
               rx_sh_d  = {rx_s_q, rx_sh_q[7:1]};
               rx_bit_d = rx_bit_q + 3'd1;
               if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_cnt_q >= div_q - 16'd1) begin
               rx_cnt_d   = '0;
               rx_state_d = RX_IDLE;
               rx_done    = rx_s_q;
            end
         end
         default: rx_state_d = RX_IDLE;
      endcase
   end

   // A byte landing during an RXDATA read wins and is not an overrun.
   always_comb begin
      rx_byte_d  = rx_byte_q;
      rx_valid_d = rx_valid_q;
      rx_ovr_d   = rd_st ? 1'b0 : rx_ovr_q;
      if (rx_done) begin
         rx_byte_d  = rx_sh_q;
         rx_valid_d = 1'b1;
         if (rx_valid_q && !rd_rx) rx_ovr_d = 1'b1;
      end else if (rd_rx) begin
         rx_valid_d = 1'b0;
      end
   end
`else
   logic unused_rx;

   assign unused_rx  = uart_rx;
   assign rx_valid   = 1'b0;
   assign rx_overrun = 1'b0;
   assign rx_byte    = 8'h00;
`endif

endmodule

`default_nettype wire

// File: tb/tb_io_uart.sv
// =====================================================================
// tb_io_uart : randomized self-checking bench for io_uart against a
//              waveform-level model of 8N1 framing.  rev 1.0
// =====================================================================
`default_nettype none

module tb_io_uart;

   logic        clk = 1'b0;
   logic        resetb = 1'b0;
   logic [7:0]  io_addr = 8'h00;
   logic        io_en = 1'b0;
   logic        io_we = 1'b0;
   logic [31:0] io_data_write = 32'h0;
   logic [31:0] io_data_read;
   logic        uart_tx;
   logic        uart_rx = 1'b1;

   int n_vec = 0;
   int n_err = 0;
   bit rec = 1'b0;
   bit log_q[$];
   bit exp_q[$];

   localparam logic [7:0] A_TX = 8'h10;
   localparam logic [7:0] A_RX = 8'h14;
   localparam logic [7:0] A_ST = 8'h18;
   localparam logic [7:0] A_DV = 8'h1C;

   always #5 clk = ~clk;

   io_uart #(
      .BASE_ADDR (4'h1),
      .TX_DEPTH  (4),
      .DIV_RESET (16'd104)
   ) dut (
      .clk           (clk),
      .resetb        (resetb),
      .io_addr       (io_addr),
      .io_en         (io_en),
      .io_we         (io_we),
      .io_data_write (io_data_write),
      .io_data_read  (io_data_read),
      .uart_tx       (uart_tx),
      .uart_rx       (uart_rx)
   );

   always @(negedge clk) if (rec) log_q.push_back(uart_tx);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
      @(negedge clk);
      io_addr = a; io_en = 1'b1; io_we = 1'b1; io_data_write = d;
      @(posedge clk);
      #1;
      io_en = 1'b0; io_we = 1'b0;
   endtask

   task automatic rd_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
      logic [31:0] d;
      @(negedge clk);
      io_addr = a; io_en = 1'b1; io_we = 1'b0;
      #1 d = io_data_read;
      check(tag, d, exp);
      @(posedge clk);
      #1;
      io_en = 1'b0;
   endtask

   // Expected line level per clock: start 0, data LSB first, stop 1.
   // Bits with index below nsw last da clocks, later bits db clocks.
   task automatic add_frame(input logic [7:0] d, input int da, input int db, input int nsw);
      for (int k = 0; k < 10; k++) begin
         bit b;
         b = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : d[k-1];
         repeat ((k < nsw) ? da : db) exp_q.push_back(b);
      end
   endtask

   task automatic start_rec();
      log_q.delete();
      exp_q.delete();
      exp_q.push_back(1'b1);
      rec = 1'b1;
   endtask

   task automatic check_log(input string tag);
      int budget;
      int n;
      budget = 0;
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
      while (log_q.size() < exp_q.size() && budget < 20000) begin
         @(posedge clk);
         budget++;
      end
      rec = 1'b0;
      check({tag, "_len"}, 32'(log_q.size() >= exp_q.size()), 32'd1);
      n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check({tag, "_tx"}, 32'(log_q[i]), 32'(exp_q[i]));
         if (log_q[i] !== exp_q[i]) break;
      end
   endtask

   task automatic rx_frame(input logic [7:0] d, input logic stopb, input int dv);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (dv) @(negedge clk);
      for (int k = 0; k < 8; k++) begin
         uart_rx = d[k];
         repeat (dv) @(negedge clk);
      end
      uart_rx = stopb;
      repeat (dv) @(negedge clk);
      uart_rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          dv, nb;
      logic [7:0]  bv [3];
      logic [7:0]  ra, rb;

      // Reset and idle register values
      repeat (3) @(negedge clk);
      check("tx_in_reset", 32'(uart_tx), 32'd1);
      resetb = 1'b1;
      check("rd_idle_bus", io_data_read, 32'h0);
      rd_check("status_rst", A_ST, 32'h02);
      rd_check("div_rst", A_DV, 32'd104);
      rd_check("txdata_rd", A_TX, 32'h0);
      rd_check("rxdata_rst", A_RX, 32'h0);
      rd_check("unselected", 8'h28, 32'h0);
      check("tx_idle", 32'(uart_tx), 32'd1);

      // Single frame with exact busy window
      bus_wr(A_DV, 32'd4);
      bus_wr(A_TX, 32'hA5);
      start_rec();
      add_frame(8'hA5, 4, 4, 10);
      io_addr = A_ST; io_en = 1'b1; io_we = 1'b0;
      for (int i = 0; i <= 41; i++) begin
         @(negedge clk);
         check("busy", 32'(io_data_read[2]), 32'((i >= 1 && i <= 40) ? 1 : 0));
      end
      io_en = 1'b0;
      check_log("frame_a5");

      // Random bursts of back-to-back frames
      for (int it = 0; it < 6; it++) begin
         dv = $urandom_range(2, 6);
         nb = $urandom_range(1, 3);
         for (int j = 0; j < 3; j++) bv[j] = 8'($urandom);
         bus_wr(A_DV, 32'(dv));
         bus_wr(A_TX, {24'h0, bv[0]});
         start_rec();
         for (int j = 1; j < nb; j++) bus_wr(A_TX, {24'h0, bv[j]});
         for (int j = 0; j < nb; j++) add_frame(bv[j], dv, dv, 10);
         check_log("rand_burst");
      end

      // Overflow: one frame in flight, then five writes into a 4-deep FIFO
      bus_wr(A_DV, 32'd4);
      bus_wr(A_TX, 32'hFF);
      start_rec();
      for (int v = 1; v <= 5; v++) bus_wr(A_TX, 32'(v));
      rd_check("status_full", A_ST, 32'h05);
      add_frame(8'hFF, 4, 4, 10);
      for (int v = 1; v <= 4; v++) add_frame(8'(v), 4, 4, 10);
      check_log("overflow");
      rd_check("status_drained", A_ST, 32'h02);

      // Divisor clamp and mid-frame divisor change
      bus_wr(A_DV, 32'd0);
      rd_check("div_clamp0", A_DV, 32'd2);
      bus_wr(A_DV, 32'd1);
      rd_check("div_clamp1", A_DV, 32'd2);
      bus_wr(A_DV, 32'hABCD_FFFF);
      rd_check("div_max", A_DV, 32'hFFFF);
      bus_wr(A_DV, 32'd4);
      bus_wr(A_TX, 32'h5A);
      start_rec();
      repeat (9) @(posedge clk);
      bus_wr(A_DV, 32'd6);
      add_frame(8'h5A, 4, 6, 3);
      check_log("div_change");

`ifdef IO_UART_RX_EN
      bus_wr(A_DV, 32'd8);
      rx_frame(8'h3C, 1'b1, 8);
      rd_check("rx_3c_valid", A_RX, 32'h13C);
      rd_check("rx_3c_clr", A_RX, 32'h03C);
      for (int it = 0; it < 2; it++) begin
         ra = 8'($urandom);
         rb = 8'($urandom);
         rx_frame(ra, 1'b1, 8);
         rx_frame(rb, 1'b1, 8);
         rd_check("rx_overrun", A_ST, 32'h1A);
         rd_check("rx_ovr_clr", A_ST, 32'h0A);
         rd_check("rx_last", A_RX, {23'h0, 1'b1, rb});
         @(negedge clk);
         uart_rx = 1'b0;
         repeat (2) @(negedge clk);
         uart_rx = 1'b1;
         repeat (20) @(negedge clk);
         rd_check("rx_glitch", A_RX, {23'h0, 1'b0, rb});
         rx_frame(ra ^ 8'hFF, 1'b0, 8);
         rd_check("rx_badstop", A_RX, {23'h0, 1'b0, rb});
      end
`else
      bus_wr(A_DV, 32'd8);
      rx_frame(8'h3C, 1'b1, 8);
      rd_check("norx_rxdata", A_RX, 32'h0);
      rd_check("norx_status", A_ST, 32'h02);
`endif

      // Asynchronous reset in the middle of a frame
      bus_wr(A_DV, 32'd6);
      bus_wr(A_TX, 32'h11);
      bus_wr(A_TX, 32'h22);
      repeat (3) @(posedge clk);
      #2;
      check("tx_midframe", 32'(uart_tx), 32'd0);
      resetb = 1'b0;
      #1;
      check("tx_async_rst", 32'(uart_tx), 32'd1);
      @(negedge clk);
      resetb = 1'b1;
      rd_check("status_after_rst", A_ST, 32'h02);
      rd_check("div_after_rst", A_DV, 32'd104);
      check("tx_after_rst", 32'(uart_tx), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
